// File: rtl/melody_sequencer.sv
// -----------------------------------------------------------------------------
// melody_sequencer
//
// Plays a two-voice score held in an external synchronous ROM and drives the
// note_gen divider and volume inputs. Handles note timing, the note-code to
// divider lookup, articulation gaps, play/pause/stop, looping and volume.
//
// Ports:
//   clk            system clock
//   rst            asynchronous, active-high reset
//   play_pause     pulse: start from IDLE/DONE, toggle pause/resume
//   stop           pulse: abort to IDLE (wins over play_pause)
//   loop_en        level: restart at address 0 on the END marker
//   tempo[1:0]     tick period = TICK_CYCLES >> tempo
//   vol_up         pulse: volume +1, saturating at 5
//   vol_down       pulse: volume -1, saturating at 0
//   score_addr     registered ROM address
//   score_data     ROM word {note_l[4:0], note_r[4:0], dur[2:0], rsvd[1:0]}
//   octave_up      level, only with MELODY_SEQ_OCTAVE_EN: play one octave up
//   note_div_left  divider to note_gen, left voice (1 = silence)
//   note_div_right divider to note_gen, right voice (1 = silence)
//   volume[2:0]    volume to note_gen, 0..5
//   playing        high in FETCH/WAIT/PLAY
//   done           high in DONE
//
// Build option: define MELODY_SEQ_OCTAVE_EN to add the octave_up input.
// -----------------------------------------------------------------------------
module melody_sequencer #(
  parameter int CLK_HZ      = 100_000_000,
  parameter int TICK_CYCLES = 6_250_000,
  parameter int GAP_CYCLES  = 500_000,
  parameter int ADDR_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              play_pause,
  input  logic              stop,
  input  logic              loop_en,
  input  logic [1:0]        tempo,
  input  logic              vol_up,
  input  logic              vol_down,
  output logic [ADDR_W-1:0] score_addr,
  input  logic [14:0]       score_data,
`ifdef MELODY_SEQ_OCTAVE_EN
  input  logic              octave_up,
`endif
  output logic [21:0]       note_div_left,
  output logic [21:0]       note_div_right,
  output logic [2:0]        volume,
  output logic              playing,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_PLAY,
    S_PAUSED,
    S_DONE
  } state_t;

  localparam int          CYC_W    = (TICK_CYCLES > 2) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [21:0] DIV_REST = 22'd1;
  localparam logic [4:0]  CODE_END = 5'd31;
  localparam logic [2:0]  VOL_MAX  = 3'd5;
  localparam logic [2:0]  VOL_RST  = 3'd3;

  // Equal-tempered C4..B5, rounded to whole Hz.
  localparam int NOTE_HZ [24] = '{
    262, 277, 294, 311, 330, 349, 370, 392, 415, 440, 466, 494,
    523, 554, 587, 622, 659, 698, 740, 784, 831, 880, 932, 988
  };

  // Elaboration-time table: code 0 and 25..31 are silence.
  function automatic logic [31:0][21:0] build_div_tab();
    logic [31:0][21:0] tab;
    for (int i = 0; i < 32; i++) begin
      if (i >= 1 && i <= 24) begin
        tab[i] = 22'(CLK_HZ / (2 * NOTE_HZ[i - 1]));
      end else begin
        tab[i] = DIV_REST;
      end
    end
    return tab;
  endfunction

  localparam logic [31:0][21:0] DIV_TAB = build_div_tab();

  function automatic logic [2:0] vol_step(input logic [2:0] v,
                                          input logic       up,
                                          input logic       dn);
    if (up && !dn && (v < VOL_MAX)) return v + 3'd1;
    if (dn && !up && (v != 3'd0))   return v - 3'd1;
    return v;
  endfunction

`ifdef MELODY_SEQ_OCTAVE_EN
  // Halving the toggle period doubles the pitch; silence stays silence.
  function automatic logic [21:0] octave_shift(input logic [21:0] div);
    if (div == DIV_REST) return DIV_REST;
    return ((div + 22'd1) >> 1) - 22'd1;
  endfunction
`endif

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [21:0]         stor_l_q, stor_l_d;
  logic [21:0]         stor_r_q, stor_r_d;
  logic [2:0]          dur_q, dur_d;
  logic [2:0]          tick_q, tick_d;
  logic [CYC_W-1:0]    cyc_q, cyc_d;
  logic [2:0]          vol_q, vol_d;
  logic [21:0]         out_l_q, out_l_d;
  logic [21:0]         out_r_q, out_r_d;
  logic                playing_q, playing_d;
  logic                done_q, done_d;

  logic [31:0]         limit;
  logic                tick_end;
  logic                note_end;
  logic                in_gap;
  logic [4:0]          note_l;
  logic [4:0]          note_r;
  logic                unused_rsvd;

  assign unused_rsvd = ^score_data[1:0];

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    stor_l_d = stor_l_q;
    stor_r_d = stor_r_q;
    dur_d    = dur_q;
    tick_d   = tick_q;
    cyc_d    = cyc_q;
    vol_d    = vol_step(vol_q, vol_up, vol_down);
    note_l   = score_data[14:10];
    note_r   = score_data[9:5];

    // Live tempo: a change mid-note applies at the next comparison, and a
    // counter already past the new limit ends the tick immediately.
    limit = 32'(TICK_CYCLES) >> tempo;
    if (limit == 32'd0) limit = 32'd1;
    tick_end = (32'(cyc_q) >= (limit - 32'd1));
    note_end = tick_end && (tick_q == dur_q);

    case (state_q)
      S_IDLE: begin
        if (play_pause) state_d = S_FETCH;
      end
      S_FETCH: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (note_l == CODE_END) begin
          if (loop_en) begin
            addr_d  = '0;
            state_d = S_FETCH;
          end else begin
            stor_l_d = DIV_REST;
            stor_r_d = DIV_REST;
            state_d  = S_DONE;
          end
        end else begin
          stor_l_d = DIV_TAB[note_l];
          stor_r_d = DIV_TAB[note_r];
          dur_d    = score_data[4:2];
          tick_d   = 3'd0;
          cyc_d    = '0;
          state_d  = S_PLAY;
        end
      end
      S_PLAY: begin
        if (tick_end) begin
          cyc_d  = '0;
          tick_d = tick_q + 3'd1;
        end else begin
          cyc_d = cyc_q + CYC_W'(1);
        end
        // A pause in the very last cycle has nothing left to pause.
        if (note_end) begin
          addr_d  = addr_q + ADDR_W'(1);
          state_d = S_FETCH;
        end else if (play_pause) begin
          state_d = S_PAUSED;
        end
      end
      S_PAUSED: begin
        if (play_pause) state_d = S_PLAY;
      end
      S_DONE: begin
        if (play_pause) begin
          addr_d  = '0;
          state_d = S_FETCH;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (stop) begin
      state_d  = S_IDLE;
      addr_d   = '0;
      stor_l_d = DIV_REST;
      stor_r_d = DIV_REST;
      tick_d   = 3'd0;
      cyc_d    = '0;
    end

    // Output stage is computed from next-state values so the registered
    // dividers line up with the state they belong to.
    in_gap = (32'(GAP_CYCLES) < limit) && (tick_d == dur_d) &&
             (32'(cyc_d) >= (limit - 32'(GAP_CYCLES)));

    case (state_d)
      S_FETCH, S_WAIT: begin
        out_l_d = stor_l_d;
        out_r_d = stor_r_d;
      end
      S_PLAY: begin
        out_l_d = in_gap ? DIV_REST : stor_l_d;
        out_r_d = in_gap ? DIV_REST : stor_r_d;
      end
      default: begin
        out_l_d = DIV_REST;
        out_r_d = DIV_REST;
      end
    endcase

`ifdef MELODY_SEQ_OCTAVE_EN
    if (octave_up) begin
      out_l_d = octave_shift(out_l_d);
      out_r_d = octave_shift(out_r_d);
    end
`endif

    playing_d = (state_d == S_FETCH) || (state_d == S_WAIT) || (state_d == S_PLAY);
    done_d    = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      stor_l_q  <= DIV_REST;
      stor_r_q  <= DIV_REST;
      dur_q     <= 3'd0;
      tick_q    <= 3'd0;
      cyc_q     <= '0;
      vol_q     <= VOL_RST;
      out_l_q   <= DIV_REST;
      out_r_q   <= DIV_REST;
      playing_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      stor_l_q  <= stor_l_d;
      stor_r_q  <= stor_r_d;
      dur_q     <= dur_d;
      tick_q    <= tick_d;
      cyc_q     <= cyc_d;
      vol_q     <= vol_d;
      out_l_q   <= out_l_d;
      out_r_q   <= out_r_d;
      playing_q <= playing_d;
      done_q    <= done_d;
    end
  end

  assign score_addr     = addr_q;
  assign note_div_left  = out_l_q;
  assign note_div_right = out_r_q;
  assign volume         = vol_q;
  assign playing        = playing_q;
  assign done           = done_q;

endmodule

// File: tb/tb_melody_sequencer.sv
// -----------------------------------------------------------------------------
// Testbench for melody_sequencer. A behavioural model tracks each note as an
// elapsed-cycle count against its total length and is compared with the DUT
// on every falling edge; directed sections pin literal values.
// -----------------------------------------------------------------------------
module tb_melody_sequencer;

  localparam int CLK_HZ = 100_000_000;
  localparam int TICK   = 16;
  localparam int GAP    = 2;
  localparam int AW     = 8;

  logic          clk        = 1'b0;
  logic          rst        = 1'b1;
  logic          play_pause = 1'b0;
  logic          stop       = 1'b0;
  logic          loop_en    = 1'b0;
  logic [1:0]    tempo      = 2'd0;
  logic          vol_up     = 1'b0;
  logic          vol_down   = 1'b0;
  logic [AW-1:0] score_addr;
  logic [14:0]   score_data;
  logic [21:0]   note_div_left;
  logic [21:0]   note_div_right;
  logic [2:0]    volume;
  logic          playing;
  logic          done;
`ifdef MELODY_SEQ_OCTAVE_EN
  logic          octave_up  = 1'b0;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  melody_sequencer #(
    .CLK_HZ(CLK_HZ), .TICK_CYCLES(TICK), .GAP_CYCLES(GAP), .ADDR_W(AW)
  ) dut (
    .clk(clk), .rst(rst), .play_pause(play_pause), .stop(stop),
    .loop_en(loop_en), .tempo(tempo), .vol_up(vol_up), .vol_down(vol_down),
    .score_addr(score_addr), .score_data(score_data),
`ifdef MELODY_SEQ_OCTAVE_EN
    .octave_up(octave_up),
`endif
    .note_div_left(note_div_left), .note_div_right(note_div_right),
    .volume(volume), .playing(playing), .done(done)
  );

  always #5 clk = ~clk;

  // Synchronous score ROM.
  logic [14:0] rom [256];
  always @(posedge clk) score_data <= rom[score_addr];

  task automatic chk(input string name, input int act, input int exp_v);
    n_checks++;
    if (act == exp_v) n_pass++;
    else begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  function automatic logic [14:0] word(input int l, input int r, input int d);
    return {5'(l), 5'(r), 3'(d), 2'b00};
  endfunction

  // Divider from first principles: 12-TET around A4 (code 10), Hz rounded.
  function automatic int ref_div(input int code);
    real f;
    int  hz;
    if (code < 1 || code > 24) return 1;
    f  = 440.0 * (2.0 ** ((code - 10) / 12.0));
    hz = $rtoi(f + 0.5);
    return CLK_HZ / (2 * hz);
  endfunction

  // ---------------- behavioural model ----------------
  localparam int M_IDLE = 0, M_FETCH = 1, M_WAIT = 2, M_PLAY = 3,
                 M_PAUSED = 4, M_DONE = 5;
  int m_state, m_addr, m_sl, m_sr, m_total, m_played, m_period, m_vol;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_state <= M_IDLE; m_addr <= 0; m_sl <= 1; m_sr <= 1;
      m_total <= 0; m_played <= 0; m_period <= TICK; m_vol <= 3;
    end else begin
      if (vol_up && !vol_down && m_vol < 5) m_vol <= m_vol + 1;
      else if (vol_down && !vol_up && m_vol > 0) m_vol <= m_vol - 1;
      if (stop) begin
        m_state <= M_IDLE; m_addr <= 0; m_sl <= 1; m_sr <= 1;
      end else begin
        case (m_state)
          M_IDLE:  if (play_pause) m_state <= M_FETCH;
          M_FETCH: m_state <= M_WAIT;
          M_WAIT: begin
            if (int'(rom[m_addr][14:10]) == 31) begin
              if (loop_en) begin m_addr <= 0; m_state <= M_FETCH; end
              else begin m_state <= M_DONE; m_sl <= 1; m_sr <= 1; end
            end else begin
              m_sl     <= ref_div(int'(rom[m_addr][14:10]));
              m_sr     <= ref_div(int'(rom[m_addr][9:5]));
              m_period <= TICK >> tempo;
              m_total  <= (int'(rom[m_addr][4:2]) + 1) * (TICK >> tempo);
              m_played <= 0;
              m_state  <= M_PLAY;
            end
          end
          M_PLAY: begin
            m_played <= m_played + 1;
            if (m_played + 1 == m_total) begin
              m_addr <= (m_addr + 1) % 256; m_state <= M_FETCH;
            end else if (play_pause) m_state <= M_PAUSED;
          end
          M_PAUSED: if (play_pause) m_state <= M_PLAY;
          M_DONE: if (play_pause) begin m_addr <= 0; m_state <= M_FETCH; end
          default: m_state <= M_IDLE;
        endcase
      end
    end
  end

  function automatic int exp_div(input int stored);
    int d;
    if (m_state == M_FETCH || m_state == M_WAIT) d = stored;
    else if (m_state == M_PLAY)
      d = (GAP < m_period && m_played >= m_total - GAP) ? 1 : stored;
    else d = 1;
`ifdef MELODY_SEQ_OCTAVE_EN
    if (octave_up && d != 1) d = ((d + 1) >> 1) - 1;
`endif
    return d;
  endfunction

  // Compare process: every falling edge outside reset.
  always @(negedge clk) begin
    if (!rst) begin
      chk("m_addr", int'(score_addr), m_addr);
      chk("m_left", int'(note_div_left), exp_div(m_sl));
      chk("m_right", int'(note_div_right), exp_div(m_sr));
      chk("m_volume", int'(volume), m_vol);
      chk("m_playing", int'(playing),
          (m_state == M_FETCH || m_state == M_WAIT || m_state == M_PLAY) ? 1 : 0);
      chk("m_done", int'(done), (m_state == M_DONE) ? 1 : 0);
    end
  end

  // ---------------- stimulus ----------------
  task automatic pulse_pp();
    @(negedge clk); play_pause = 1'b1;
    @(negedge clk); play_pause = 1'b0;
  endtask

  task automatic pulse_stop();
    @(negedge clk); stop = 1'b1;
    @(negedge clk); stop = 1'b0;
  endtask

  int cnt_a, cnt_b;

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 15'd0;
    rom[0] = word(10, 1, 0);   // A4 / C4, one tick
    rom[1] = word(31, 0, 0);   // END

    repeat (3) @(negedge clk);
    chk("rst_left", int'(note_div_left), 1);
    chk("rst_right", int'(note_div_right), 1);
    chk("rst_volume", int'(volume), 3);
    chk("rst_addr", int'(score_addr), 0);
    chk("rst_playing", int'(playing), 0);
    chk("rst_done", int'(done), 0);
    rst = 1'b0;

    // Single note, no loop: latency, gap, DONE.
    pulse_pp();                       // FETCH visible now
    @(negedge clk);                   // WAIT
    @(negedge clk);                   // first PLAY cycle
    chk("a4_left", int'(note_div_left), 113636);
    chk("c4_right", int'(note_div_right), 190839);
    repeat (13) @(negedge clk);
    chk("note_last_left", int'(note_div_left), 113636);
    @(negedge clk);
    chk("gap1_left", int'(note_div_left), 1);
    chk("gap1_right", int'(note_div_right), 1);
    @(negedge clk);
    chk("gap2_left", int'(note_div_left), 1);
    @(negedge clk);
    chk("fetch_hold_left", int'(note_div_left), 113636);
    chk("fetch_addr", int'(score_addr), 1);
    repeat (2) @(negedge clk);
    chk("done_flag", int'(done), 1);
    chk("done_left", int'(note_div_left), 1);

    // Looping: 20-cycle period, 2 gap cycles each, never done.
    pulse_stop();
    loop_en = 1'b1;
    pulse_pp();
    repeat (2) @(negedge clk);
    cnt_a = 0; cnt_b = 0;
    for (int c = 0; c < 100; c++) begin
      if (note_div_left == 22'd1) cnt_a++;
      if (done) cnt_b++;
      @(negedge clk);
    end
    chk("loop_gap_cycles", cnt_a, 10);
    chk("loop_done_cycles", cnt_b, 0);

    // Pause at cycle 5 of a two-tick note, resume 100 cycles later.
    pulse_stop();
    loop_en = 1'b0;
    rom[0] = word(10, 13, 1);
    @(negedge clk); play_pause = 1'b1;
    @(negedge clk); play_pause = 1'b0;
    cnt_a = 0;
    for (int c = 2; c < 200; c++) begin
      @(negedge clk);
      if (note_div_left == 22'd113636 && score_addr == 0) cnt_a++;
      if (c == 3) chk("c5_right", int'(note_div_right), 95602);
      if (c == 50) begin
        chk("paused_left", int'(note_div_left), 1);
        chk("paused_playing", int'(playing), 0);
      end
      play_pause = (c == 8 || c == 108);
    end
    chk("pause_note_cycles", cnt_a, 30);
    chk("pause_addr", int'(score_addr), 1);
    chk("pause_done", int'(done), 1);

    // Volume saturation.
    for (int i = 0; i < 4; i++) begin @(negedge clk); vol_up = 1'b1; end
    @(negedge clk); vol_up = 1'b0;
    chk("vol_sat_hi", int'(volume), 5);
    vol_up = 1'b1; vol_down = 1'b1;
    @(negedge clk); vol_up = 1'b0; vol_down = 1'b0;
    @(negedge clk);
    chk("vol_both", int'(volume), 5);
    for (int i = 0; i < 6; i++) begin @(negedge clk); vol_down = 1'b1; end
    @(negedge clk); vol_down = 1'b0;
    chk("vol_sat_lo", int'(volume), 0);

    // stop and play_pause together during PLAY.
    pulse_stop();
    pulse_pp();
    repeat (4) @(negedge clk);
    stop = 1'b1; play_pause = 1'b1;
    @(negedge clk); stop = 1'b0; play_pause = 1'b0;
    chk("stop_left", int'(note_div_left), 1);
    chk("stop_right", int'(note_div_right), 1);
    chk("stop_playing", int'(playing), 0);
    chk("stop_addr", int'(score_addr), 0);

    // Asynchronous reset in the middle of a note.
    pulse_pp();
    repeat (5) @(negedge clk);
    #1 rst = 1'b1;
    #2 rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_left", int'(note_div_left), 1);
    chk("mid_rst_volume", int'(volume), 3);
    chk("mid_rst_addr", int'(score_addr), 0);
    chk("mid_rst_playing", int'(playing), 0);

`ifdef MELODY_SEQ_OCTAVE_EN
    octave_up = 1'b1;
    rom[0] = word(10, 0, 0);
    pulse_pp();
    repeat (2) @(negedge clk);
    chk("octave_a4", int'(note_div_left), 56817);
    pulse_stop();
    octave_up = 1'b0;
`endif

    // Randomized segments; tempo and ROM only change while stopped.
    for (int seg = 0; seg < 4; seg++) begin
      pulse_stop();
      tempo   = 2'($urandom_range(0, 3));
      loop_en = 1'($urandom_range(0, 1));
      for (int i = 0; i < 256; i++) begin
        if ($urandom_range(0, 7) == 0) rom[i] = word(31, $urandom_range(0, 31), $urandom_range(0, 7));
        else rom[i] = word($urandom_range(0, 30), $urandom_range(0, 31), $urandom_range(0, 7));
      end
      for (int c = 0; c < 2500; c++) begin
        @(negedge clk);
        play_pause = ($urandom_range(0, 59) == 0);
        stop       = ($urandom_range(0, 499) == 0);
        vol_up     = ($urandom_range(0, 9) == 0);
        vol_down   = ($urandom_range(0, 9) == 0);
        if ($urandom_range(0, 199) == 0) loop_en = ~loop_en;
      end
      @(negedge clk);
      play_pause = 1'b0; stop = 1'b0; vol_up = 1'b0; vol_down = 1'b0;
    end

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
